// File: rtl/wb_ctrl_pkg.sv
// Shared writeback-stage constants: mux select codes and controller state encoding.
package klp32_wb_pkg;

    localparam logic [1:0] WB_MEM  = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_PC   = 2'd2;
    localparam logic [1:0] WB_RSVD = 2'd3;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    // Load timer width; a 1-bit counter still covers the smallest legal timeout.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Retire handshake, memory response and register-file write port of the writeback stage.
interface wb_ctrl_if #(
    parameter int unsigned RET_W = 32
) ();
    logic             instr_valid;
    logic             instr_ready;
    logic [4:0]       instr_rd;
    logic [1:0]       instr_wb_sel;
    logic             instr_reg_write;
    logic             mem_rsp_valid;
    logic [1:0]       wb_select;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic             load_fault;
    logic             illegal_sel;
    logic             spurious_rsp;
    logic [RET_W-1:0] instret;

    modport master (
        output instr_valid, instr_rd, instr_wb_sel, instr_reg_write, mem_rsp_valid,
        input  instr_ready, wb_select, rf_we, rf_waddr, load_fault, illegal_sel,
        input  spurious_rsp, instret
    );

    modport slave (
        input  instr_valid, instr_rd, instr_wb_sel, instr_reg_write, mem_rsp_valid,
        output instr_ready, wb_select, rf_we, rf_waddr, load_fault, illegal_sel,
        output spurious_rsp, instret
    );
endinterface

// File: rtl/wb_ctrl_load_timer.sv
// Clearable up-counter timing a pending load; o_tc flags the last cycle before timeout.
module wb_load_timer
    import klp32_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int unsigned W = timer_width(TIMEOUT);

    logic [W-1:0] r_cnt;

    // Count while waiting; clear wins so a newly accepted load starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // Terminal count is TIMEOUT-1, i.e. the TIMEOUT-th cycle spent waiting.
    assign o_tc = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: retires instructions, waits for load data, drives the RF write port.
module wb_ctrl
    import klp32_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RET_W   = 32
) (
    input logic      clk,
    input logic      rst_n,
    wb_ctrl_if.slave bus
);
    wb_state_e        r_state, w_state_d;
    logic [4:0]       r_rd, w_rd_d;
    logic             r_rw, w_rw_d;
    logic [1:0]       r_wb_select, w_wb_select_d;
    logic             r_rf_we, w_rf_we_d;
    logic [4:0]       r_rf_waddr, w_rf_waddr_d;
    logic             r_load_fault, w_load_fault_d;
    logic             r_illegal_sel, w_illegal_sel_d;
    logic             r_spurious, w_spurious_d;
    logic [RET_W-1:0] r_instret, w_instret_d;
    logic             w_timer_clr;
    logic             w_timer_tc;
    logic             w_in_wait;

    assign w_in_wait = (r_state == WAIT_MEM);

    wb_load_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_timer_clr),
        .i_en  (w_in_wait),
        .o_tc  (w_timer_tc)
    );

    // Next-state and registered-output decode; select/address only move on a real write.
    always_comb begin
        w_state_d       = r_state;
        w_rd_d          = r_rd;
        w_rw_d          = r_rw;
        w_wb_select_d   = r_wb_select;
        w_rf_we_d       = 1'b0;
        w_rf_waddr_d    = r_rf_waddr;
        w_load_fault_d  = 1'b0;
        w_illegal_sel_d = 1'b0;
        w_instret_d     = r_instret;
        w_timer_clr     = 1'b0;
        // A response is only meaningful while a load is pending.
        w_spurious_d    = r_spurious | (bus.mem_rsp_valid & ~w_in_wait);

        unique case (r_state)
            IDLE: begin
                if (bus.instr_valid) begin
                    unique case (bus.instr_wb_sel)
                        WB_MEM: begin
                            w_rd_d      = bus.instr_rd;
                            w_rw_d      = bus.instr_reg_write;
                            w_timer_clr = 1'b1;
                            w_state_d   = WAIT_MEM;
                        end
                        WB_ALU, WB_PC: begin
                            w_instret_d = r_instret + RET_W'(1);
                            if (bus.instr_reg_write && (bus.instr_rd != 5'd0)) begin
                                w_rf_we_d     = 1'b1;
                                w_wb_select_d = bus.instr_wb_sel;
                                w_rf_waddr_d  = bus.instr_rd;
                            end
                        end
                        WB_RSVD: begin
                            w_illegal_sel_d = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                // Response is checked first so it wins over the terminal timer cycle.
                if (bus.mem_rsp_valid) begin
                    w_instret_d = r_instret + RET_W'(1);
                    w_state_d   = IDLE;
                    if (r_rw && (r_rd != 5'd0)) begin
                        w_rf_we_d     = 1'b1;
                        w_wb_select_d = WB_MEM;
                        w_rf_waddr_d  = r_rd;
                    end
                end else if (w_timer_tc) begin
                    w_load_fault_d = 1'b1;
                    w_state_d      = IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset drops any pending load without side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rd          <= 5'd0;
            r_rw          <= 1'b0;
            r_wb_select   <= WB_MEM;
            r_rf_we       <= 1'b0;
            r_rf_waddr    <= 5'd0;
            r_load_fault  <= 1'b0;
            r_illegal_sel <= 1'b0;
            r_spurious    <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_state       <= w_state_d;
            r_rd          <= w_rd_d;
            r_rw          <= w_rw_d;
            r_wb_select   <= w_wb_select_d;
            r_rf_we       <= w_rf_we_d;
            r_rf_waddr    <= w_rf_waddr_d;
            r_load_fault  <= w_load_fault_d;
            r_illegal_sel <= w_illegal_sel_d;
            r_spurious    <= w_spurious_d;
            r_instret     <= w_instret_d;
        end
    end

    assign bus.instr_ready  = (r_state == IDLE);
    assign bus.wb_select    = r_wb_select;
    assign bus.rf_we        = r_rf_we;
    assign bus.rf_waddr     = r_rf_waddr;
    assign bus.load_fault   = r_load_fault;
    assign bus.illegal_sel  = r_illegal_sel;
    assign bus.spurious_rsp = r_spurious;
    assign bus.instret      = r_instret;

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed retire/load sequences, a per-cycle reference model and literal checks.
`timescale 1ns/1ps
module tb_wb_ctrl;
    import klp32_wb_pkg::*;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_ctrl_if #(.RET_W(32)) bus ();
    wb_ctrl #(.TIMEOUT(TO), .RET_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Narrow-counter, minimum-timeout instance for the wrap and short-timeout corners.
    wb_ctrl_if #(.RET_W(3)) bus2 ();
    wb_ctrl #(.TIMEOUT(2), .RET_W(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Stand-in for writeback_mux at the stage top.
    logic [31:0] alu_in, pc_in, mem_in, wb_data;
    always_comb begin
        case (bus.wb_select)
            WB_MEM:  wb_data = mem_in;
            WB_ALU:  wb_data = alu_in;
            WB_PC:   wb_data = pc_in;
            default: wb_data = 32'd0;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whether a load is outstanding and how long since it was accepted.
    logic        m_busy, m_rw, m_we, m_fault, m_ill, m_spur;
    int          m_age;
    logic [4:0]  m_rd, m_waddr;
    logic [1:0]  m_sel;
    logic [31:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_rw <= 1'b0; m_we <= 1'b0; m_fault <= 1'b0; m_ill <= 1'b0;
            m_spur <= 1'b0; m_age <= 0; m_rd <= 5'd0; m_waddr <= 5'd0; m_sel <= 2'd0;
            m_cnt <= 32'd0;
        end else begin
            m_we <= 1'b0; m_fault <= 1'b0; m_ill <= 1'b0;
            if (!m_busy) begin
                if (bus.mem_rsp_valid) m_spur <= 1'b1;
                if (bus.instr_valid) begin
                    if (bus.instr_wb_sel == WB_MEM) begin
                        m_busy <= 1'b1; m_age <= 0;
                        m_rd <= bus.instr_rd; m_rw <= bus.instr_reg_write;
                    end else if (bus.instr_wb_sel == WB_RSVD) begin
                        m_ill <= 1'b1;
                    end else begin
                        m_cnt <= m_cnt + 32'd1;
                        if (bus.instr_reg_write && bus.instr_rd != 5'd0) begin
                            m_we <= 1'b1; m_sel <= bus.instr_wb_sel; m_waddr <= bus.instr_rd;
                        end
                    end
                end
            end else begin
                m_age <= m_age + 1;
                if (bus.mem_rsp_valid) begin
                    m_busy <= 1'b0; m_cnt <= m_cnt + 32'd1;
                    if (m_rw && m_rd != 5'd0) begin
                        m_we <= 1'b1; m_sel <= WB_MEM; m_waddr <= m_rd;
                    end
                end else if (m_age + 1 == int'(TO)) begin
                    m_fault <= 1'b1; m_busy <= 1'b0;
                end
            end
        end
    end

    // Every out-of-reset cycle, compare the DUT against the model on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk1("m_ready", bus.instr_ready, !m_busy);
            chk1("m_rf_we", bus.rf_we, m_we);
            chk1("m_load_fault", bus.load_fault, m_fault);
            chk1("m_illegal_sel", bus.illegal_sel, m_ill);
            chk1("m_spurious", bus.spurious_rsp, m_spur);
            chk32("m_instret", bus.instret, m_cnt);
            if (m_we) begin
                chk32("m_wb_select", 32'(bus.wb_select), 32'(m_sel));
                chk32("m_rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                         input logic rw, input logic rsp);
        bus.instr_valid = v; bus.instr_wb_sel = sel; bus.instr_rd = rd;
        bus.instr_reg_write = rw; bus.mem_rsp_valid = rsp;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, WB_ALU, 5'd0, 1'b0, 1'b0);
        bus2.instr_valid = 1'b0; bus2.instr_wb_sel = WB_ALU; bus2.instr_rd = 5'd1;
        bus2.instr_reg_write = 1'b1; bus2.mem_rsp_valid = 1'b0;
        alu_in = 32'h0020_0113; pc_in = 32'h0000_1004; mem_in = 32'h1010_1010;

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_ready", bus.instr_ready, 1'b1);
        chk1("rst_rf_we", bus.rf_we, 1'b0);
        chk32("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        chk32("rst_sel", 32'(bus.wb_select), 32'd0);
        chk32("rst_instret", bus.instret, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // ALU rd=3: written one cycle after accept.
        drive(1'b1, WB_ALU, 5'd3, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, WB_ALU, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("alu_we", bus.rf_we, 1'b1);
        chk32("alu_waddr", 32'(bus.rf_waddr), 32'd3);
        chk32("alu_sel", 32'(bus.wb_select), 32'd1);
        chk32("alu_data", wb_data, 32'h0020_0113);
        chk32("alu_instret", bus.instret, 32'd1);

        // Load rd=5, response three cycles after accept.
        next_cycle();
        drive(1'b1, WB_MEM, 5'd5, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, WB_MEM, 5'd5, 1'b1, 1'b0);
        chk1("ld_ready_c1", bus.instr_ready, 1'b0);
        next_cycle();
        chk1("ld_ready_c2", bus.instr_ready, 1'b0);
        next_cycle();
        chk1("ld_ready_c3", bus.instr_ready, 1'b0);
        bus.mem_rsp_valid = 1'b1;
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("ld_we", bus.rf_we, 1'b1);
        chk32("ld_waddr", 32'(bus.rf_waddr), 32'd5);
        chk32("ld_sel", 32'(bus.wb_select), 32'd0);
        chk32("ld_data", wb_data, 32'h1010_1010);
        chk1("ld_ready_after", bus.instr_ready, 1'b1);

        // Load with no response: fault exactly TO+1 cycles after accept.
        next_cycle();
        drive(1'b1, WB_MEM, 5'd7, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, WB_MEM, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk1($sformatf("to_fault_c%0d", k), bus.load_fault, k == 5);
            chk1($sformatf("to_we_c%0d", k), bus.rf_we, 1'b0);
            if (k < 5) next_cycle();
        end
        chk32("to_instret", bus.instret, 32'd2);
        next_cycle();
        drive(1'b1, WB_PC, 5'd1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, WB_ALU, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("pc_we", bus.rf_we, 1'b1);
        chk32("pc_sel", 32'(bus.wb_select), 32'd2);
        chk32("pc_data", wb_data, 32'h0000_1004);

        // Back-to-back: ALU rd=0, PC rd=1, reserved select.
        next_cycle();
        drive(1'b1, WB_ALU, 5'd0, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, WB_PC, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk1("b2b_we0", bus.rf_we, 1'b0);
        next_cycle();
        drive(1'b1, WB_RSVD, 5'd2, 1'b1, 1'b0);
        @(negedge clk);
        chk1("b2b_we1", bus.rf_we, 1'b1);
        next_cycle();
        drive(1'b0, WB_ALU, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("b2b_we2", bus.rf_we, 1'b0);
        chk1("b2b_illegal", bus.illegal_sel, 1'b1);
        chk32("b2b_instret", bus.instret, 32'd5);

        // Response while idle is flagged and sticks.
        next_cycle();
        bus.mem_rsp_valid = 1'b1;
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        next_cycle();
        next_cycle();
        chk1("spur_sticky", bus.spurious_rsp, 1'b1);

        // Response on the accept cycle is ignored; one in the terminal timer cycle wins.
        drive(1'b1, WB_MEM, 5'd6, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, WB_MEM, 5'd0, 1'b0, 1'b0);
        chk1("term_ready_c1", bus.instr_ready, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        bus.mem_rsp_valid = 1'b1;
        next_cycle();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("term_we", bus.rf_we, 1'b1);
        chk1("term_fault", bus.load_fault, 1'b0);
        chk32("term_waddr", 32'(bus.rf_waddr), 32'd6);
        chk32("term_instret", bus.instret, 32'd6);

        // Asynchronous reset while a load is pending.
        next_cycle();
        drive(1'b1, WB_MEM, 5'd9, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, WB_MEM, 5'd0, 1'b0, 1'b0);
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_ready", bus.instr_ready, 1'b1);
        chk1("arst_spur", bus.spurious_rsp, 1'b0);
        chk32("arst_instret", bus.instret, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        repeat (6) next_cycle();
        chk1("arst_no_we", bus.rf_we, 1'b0);
        chk1("arst_no_fault", bus.load_fault, 1'b0);

        // Narrow counter wraps after 2^3 completions.
        bus2.instr_valid = 1'b1;
        repeat (7) next_cycle();
        @(negedge clk);
        chk32("wrap_pre", 32'(bus2.instret), 32'd7);
        next_cycle();
        bus2.instr_valid = 1'b0;
        @(negedge clk);
        chk32("wrap_zero", 32'(bus2.instret), 32'd0);
        chk1("wrap_we", bus2.rf_we, 1'b1);

        // Minimum timeout: fault three cycles after accept.
        next_cycle();
        bus2.instr_valid = 1'b1; bus2.instr_wb_sel = WB_MEM;
        next_cycle();
        bus2.instr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk1($sformatf("to2_fault_c%0d", k), bus2.load_fault, k == 3);
            if (k < 3) next_cycle();
        end

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback-stage controller for the KLP32 RISC-V core. It accepts retiring instructions from the execute/memory stage and waits for load data when the instruction is a load. It drives `writeback_mux.wb_select` and the register-file write port (`rf_we`, `rf_waddr`). It also keeps a retired-instruction counter, suppresses writes to x0, and times out loads whose response never arrives.

## Interface
- `TIMEOUT`, 16: cycles to wait in WAIT_MEM for `mem_rsp_valid`; legal range 2..255.
- `RET_W`, 32: width of the `instret` counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: upstream has a retiring instruction.
- `instr_ready` out 1: controller can accept; combinational, equals (state==IDLE).
- `instr_rd` in 5: destination register.
- `instr_wb_sel` in 2: 0 MEM, 1 ALU, 2 PC (link value), 3 reserved.
- `instr_reg_write` in 1: instruction writes rd.
- `mem_rsp_valid` in 1: load data present on `mem_in` of the mux this cycle.
- `wb_select` out 2: registered select to `writeback_mux`.
- `rf_we` out 1: registered register-file write strobe, one cycle.
- `rf_waddr` out 5: registered write address.
- `load_fault` out 1: one-cycle pulse when a load times out.
- `illegal_sel` out 1: one-cycle pulse when sel=3 is accepted.
- `spurious_rsp` out 1: sticky flag; `mem_rsp_valid` arrived outside WAIT_MEM. Cleared only by reset.
- `instret` out RET_W: count of completed instructions; wraps.

## Operation
- **Accept.** An instruction is accepted when `instr_valid & instr_ready`. Upstream holds all `instr_*` inputs stable while `instr_ready` = 0.
- **IDLE, sel ALU/PC:**
  - Next cycle: `wb_select`=sel, `rf_waddr`=rd, `rf_we`=`instr_reg_write` & (rd≠0), `instret`+1.
  - State stays IDLE, so back-to-back accepts run at one per cycle.
- **IDLE, sel MEM:**
  - Latch rd and reg_write, clear the timer, go to WAIT_MEM. `rf_we`=0 next cycle.
- **IDLE, sel 3:**
  - No write and no `instret` increment; `illegal_sel` pulses next cycle. State stays IDLE.
- **WAIT_MEM:**
  - `instr_ready`=0 and the timer increments every cycle.
  - On `mem_rsp_valid`: next cycle `wb_select`=0, `rf_we`=latched reg_write & (rd≠0), `instret`+1, state returns to IDLE.
  - If the timer reaches TIMEOUT−1 without a response: next cycle `load_fault`=1, no write, no `instret` increment, state returns to IDLE.
- **Simultaneous events:**
  - A response arriving in the terminal timer cycle wins: the write happens and there is no fault.
  - `mem_rsp_valid` in IDLE is ignored for data and sets `spurious_rsp`. This includes a response arriving in the same cycle a load is accepted.
- **Reset mid-operation:** a pending load is dropped with no write and no fault pulse.
- `wb_select` holds its last value when `rf_we`=0.
- `instret` wraps from 2^RET_W−1 to 0.

## Timing
- Reset values: state IDLE (`instr_ready`=1), `wb_select`=0, `rf_we`=0, `rf_waddr`=0, `load_fault`=0, `illegal_sel`=0, `spurious_rsp`=0, `instret`=0, timer 0.
- Latency from accept to `rf_we`:
  - ALU/PC: 1 cycle.
  - Load: 1 cycle after `mem_rsp_valid`, at minimum 2 cycles after accept.
- Load timeout: `load_fault` asserts TIMEOUT+1 cycles after accept.
- The datapath holds `alu_in`/`pc_in`/`mem_in` valid in the cycle `rf_we`=1; the mux output is combinational from the registered `wb_select`.

## Structure
- Shared package `klp32_wb_pkg` holds:
  - the select constants WB_MEM=2'd0, WB_ALU=2'd1, WB_PC=2'd2, WB_RSVD=2'd3;
  - the state encoding IDLE/WAIT_MEM.
  - `writeback_mux` and decode both import these constants.
- One sub-module is natural: `wb_load_timer`, a clearable up-counter of width clog2(TIMEOUT) with a terminal-count output.
- `writeback_mux` is instantiated beside the controller at the stage top, not inside it.

## Test plan
- Reset, then ALU instr (rd=3, reg_write=1, alu_in=0x00200113) accepted → next cycle `rf_we`=1, `rf_waddr`=3, `wb_select`=1, writeback=0x00200113, `instret`=1.
- Load rd=5, `mem_rsp_valid` 3 cycles after accept with mem_in=0x10101010 → `instr_ready`=0 during the wait; 1 cycle after the response `rf_we`=1, `rf_waddr`=5, `wb_select`=0; back in IDLE.
- Load with no response, TIMEOUT=4 → `load_fault` pulses 5 cycles after accept, `rf_we` stays 0, `instret` unchanged; then a PC instr rd=1 → `rf_we`=1, `wb_select`=2.
- Back-to-back: ALU rd=0, PC rd=1, sel=3 rd=2 over 3 consecutive cycles → `rf_we` sequence 0,1,0; `illegal_sel` pulses on the third result cycle; `instret` +2.
- `mem_rsp_valid` in IDLE → `spurious_rsp`=1 and stays set. Response in the terminal timer cycle → write occurs, no `load_fault`.
- `rst_n` low while in WAIT_MEM → all outputs at reset values immediately (asynchronously); no write after release. Preload `instret`=0xFFFFFFFF, then complete one instruction → `instret`=0.
